// File: rtl/beta_sequencer.sv
// beta_sequencer: multicycle fetch/decode/execute/memory/writeback sequencer for
// the Beta core, stepping imem, dmem and the MUL/DIV unit through req/ack handshakes.
module beta_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] instr,
  output logic [31:0] ir,
  output logic [5:0]  ctl_addr,
  input  logic [11:0] ctl_word,
  output logic [11:0] cw,
  output logic        alu_start,
  input  logic        alu_done,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic        z,
  output logic        rf_we,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        illop,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ILLOP  = 3'd6
  } state_t;

  state_t      state_r;
  logic [31:0] ir_r;
  logic [11:0] cw_r;
  logic [31:0] instret_r;
  logic        imem_req_r;
  logic        alu_start_r;
  logic        dmem_req_r;
  logic        dmem_we_r;
  logic        rf_we_r;
  logic        pc_en_r;
  logic [1:0]  pc_sel_r;
  logic        illop_r;

  // ALUFN 3 (MUL) and 4 (DIV) are the only multicycle ALU operations.
  function automatic logic is_muldiv(input logic [11:0] word);
    return (word[11:8] == 4'd3) || (word[11:8] == 4'd4);
  endfunction

  function automatic logic [1:0] wb_pc_sel(input logic [1:0] pcsel, input logic zf);
    logic [1:0] sel;
    case (pcsel)
      2'b01:   sel = zf ? 2'b01 : 2'b00;
      2'b10:   sel = 2'b10;
      2'b11:   sel = zf ? 2'b00 : 2'b01;
      default: sel = 2'b00;
    endcase
    return sel;
  endfunction

  // Sequencer state, datapath registers and registered strobes for the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      ir_r        <= 32'h0000_0000;
      cw_r        <= 12'h000;
      instret_r   <= 32'h0000_0000;
      imem_req_r  <= 1'b0;
      alu_start_r <= 1'b0;
      dmem_req_r  <= 1'b0;
      dmem_we_r   <= 1'b0;
      rf_we_r     <= 1'b0;
      pc_en_r     <= 1'b0;
      pc_sel_r    <= 2'b00;
      illop_r     <= 1'b0;
    end else begin
      imem_req_r  <= 1'b0;
      alu_start_r <= 1'b0;
      dmem_req_r  <= 1'b0;
      dmem_we_r   <= 1'b0;
      rf_we_r     <= 1'b0;
      pc_en_r     <= 1'b0;
      pc_sel_r    <= 2'b00;
      illop_r     <= 1'b0;
      case (state_r)
        S_IDLE: begin
          state_r    <= S_FETCH;
          imem_req_r <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir_r    <= instr;
            state_r <= S_DECODE;
          end else begin
            imem_req_r <= 1'b1;
          end
        end
        S_DECODE: begin
          cw_r <= ctl_word;
          if (ctl_word == 12'h000) begin
            state_r  <= S_ILLOP;
            rf_we_r  <= 1'b1;
            pc_en_r  <= 1'b1;
            pc_sel_r <= 2'b11;
            illop_r  <= 1'b1;
          end else begin
            state_r     <= S_EXEC;
            alu_start_r <= is_muldiv(ctl_word);
          end
        end
        S_EXEC: begin
          if (is_muldiv(cw_r) && !alu_done) begin
            state_r <= S_EXEC;
          end else if (cw_r[5] | cw_r[3]) begin
            state_r    <= S_MEM;
            dmem_req_r <= 1'b1;
            dmem_we_r  <= cw_r[3];
          end else begin
            state_r  <= S_WB;
            rf_we_r  <= cw_r[7];
            pc_en_r  <= 1'b1;
            pc_sel_r <= wb_pc_sel(cw_r[1:0], z);
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            state_r  <= S_WB;
            rf_we_r  <= cw_r[7];
            pc_en_r  <= 1'b1;
            pc_sel_r <= wb_pc_sel(cw_r[1:0], z);
          end else begin
            dmem_req_r <= 1'b1;
            dmem_we_r  <= cw_r[3];
          end
        end
        S_WB: begin
          instret_r  <= instret_r + 32'd1;
          state_r    <= S_FETCH;
          imem_req_r <= 1'b1;
        end
        S_ILLOP: begin
          state_r    <= S_FETCH;
          imem_req_r <= 1'b1;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign ir        = ir_r;
  assign ctl_addr  = ir_r[31:26];
  assign cw        = cw_r;
  assign instret   = instret_r;
  assign imem_req  = imem_req_r;
  assign alu_start = alu_start_r;
  assign dmem_req  = dmem_req_r;
  assign dmem_we   = dmem_we_r;
  assign rf_we     = rf_we_r;
  assign pc_en     = pc_en_r;
  assign pc_sel    = pc_sel_r;
  assign illop     = illop_r;

endmodule
